// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor.
// Operands are captured on a start request and shifted through a registered
// 1-bit add/sub slice LSB first. After WIDTH bit-cycles the result, carry
// (no-borrow on subtract) and signed overflow are published with a done pulse.
//
// state | meaning
// IDLE  | waiting for start_in; outputs hold the last completed result
// SHIFT | one operand bit per clock through the slice, cnt_r = bit index
// DONE  | done_out high for this single cycle, then back to IDLE
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             opcode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             flag_out,
    output logic             overflow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             op_r;
    logic             carry_r;
    logic             cmsb_r;

    logic b_bit;
    logic sum_bit;
    logic c_bit;

    // 1-bit add/sub slice: subtract inverts B, the +1 comes from the preset carry
    always_comb begin
        b_bit   = b_r[0] ^ op_r;
        sum_bit = a_r[0] ^ b_bit ^ carry_r;
        c_bit   = (a_r[0] & b_bit) | (a_r[0] & carry_r) | (b_bit & carry_r);
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = SHIFT;
            SHIFT:   if (cnt_r == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_out = (state != IDLE);

    // Datapath: operand capture, bit-serial shift, result publication
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_r          <= '0;
            b_r          <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            op_r         <= 1'b0;
            carry_r      <= 1'b0;
            cmsb_r       <= 1'b0;
            done_out     <= 1'b0;
            result_out   <= '0;
            flag_out     <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_r     <= a_in;
                        b_r     <= b_in;
                        acc_r   <= '0;
                        op_r    <= opcode_in;
                        carry_r <= opcode_in;
                        cnt_r   <= '0;
                        cmsb_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    carry_r <= c_bit;
                    acc_r   <= {sum_bit, acc_r[WIDTH-1:1]};
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    cnt_r   <= cnt_r + 1'b1;
                    if (cnt_r == MSB_M1) begin
                        cmsb_r <= c_bit;
                    end
                    if (cnt_r == LAST_BIT) begin
                        result_out   <= {sum_bit, acc_r[WIDTH-1:1]};
                        flag_out     <= c_bit;
                        overflow_out <= c_bit ^ cmsb_r;
                        done_out     <= 1'b1;
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                end
                default: begin
                    done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: the driver decides from its own timing
// model whether a start is accepted and queues the arithmetic expectation; the
// monitor checks done/busy/result every cycle against that queue.
module tb_serial_add_sub;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        logic [W-1:0] res;
        logic         flag;
        logic         ovf;
        int           done_edge;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         rst_n_in = 1'b0;
    logic         start_in = 1'b0;
    logic         opcode_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] result_out;
    logic         flag_out;
    logic         overflow_out;

    int n_vec  = 0;
    int n_fail = 0;
    int edge_n = 0;

    exp_t         sb[$];
    int           free_edge = 0;
    int           last_acc  = -100;
    logic [W-1:0] last_res  = '0;
    logic         last_flag = 1'b0;
    logic         last_ovf  = 1'b0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .start_in     (start_in),
        .opcode_in    (opcode_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .result_out   (result_out),
        .flag_out     (flag_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference arithmetic from plain integer math
    function automatic exp_t model(input bit op, input int a, input int b, input int de);
        exp_t e;
        int   sres;
        e.res  = W'(op ? (a - b) & MASK : (a + b) & MASK);
        e.flag = op ? (a >= b) : ((a + b) > MASK);
        sres   = op ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
        e.ovf  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
        e.done_edge = de;
        return e;
    endfunction

    // One clock of stimulus; a start is accepted only if the model is idle at the coming edge
    task automatic drive(input bit s, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        @(negedge clk_in);
        #1;
        start_in  = s;
        opcode_in = op;
        a_in      = a;
        b_in      = b;
        k = edge_n + 1;
        if (s && rst_n_in && k >= free_edge) begin
            sb.push_back(model(op, int'(a), int'(b), k + W));
            last_acc  = k;
            free_edge = k + W + 2;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic op_once(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, op, a, b);
        idle_cycles(W + 3);
    endtask

    // Monitor: done timing, busy window, and result hold/update each cycle
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            chk("busy", int'(busy_out),
                int'((edge_n >= last_acc) && (edge_n < last_acc + W + 1)));
            if (sb.size() > 0 && sb[0].done_edge == edge_n) begin
                exp_t e;
                e = sb.pop_front();
                chk("done_pulse", int'(done_out), 1);
                chk("result", int'(result_out), int'(e.res));
                chk("flag", int'(flag_out), int'(e.flag));
                chk("overflow", int'(overflow_out), int'(e.ovf));
                last_res  = e.res;
                last_flag = e.flag;
                last_ovf  = e.ovf;
            end else begin
                chk("done_idle", int'(done_out), 0);
                chk("result_hold", int'(result_out), int'(last_res));
                chk("flag_hold", int'(flag_out), int'(last_flag));
                chk("ovf_hold", int'(overflow_out), int'(last_ovf));
            end
        end
    end

    initial begin
        #23;
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_result", int'(result_out), 0);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
        idle_cycles(2);

        // Directed arithmetic cases
        op_once(1'b0, 8'h35, 8'h4A);
        op_once(1'b0, 8'hFF, 8'h01);
        op_once(1'b0, 8'h7F, 8'h01);
        op_once(1'b1, 8'h10, 8'h20);
        op_once(1'b1, 8'h80, 8'h01);
        op_once(1'b1, 8'h55, 8'h00);
        op_once(1'b1, 8'h00, 8'hFF);

        // Start pulse while busy must be ignored
        drive(1'b1, 1'b0, 8'h35, 8'h4A);
        idle_cycles(2);
        drive(1'b1, 1'b0, 8'h01, 8'h01);
        idle_cycles(W + 4);

        // Asynchronous reset mid-operation discards the partial result
        drive(1'b1, 1'b0, 8'h35, 8'h4A);
        idle_cycles(3);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        sb.delete();
        last_acc  = -100;
        free_edge = 0;
        last_res  = '0;
        last_flag = 1'b0;
        last_ovf  = 1'b0;
        #1;
        chk("async_busy", int'(busy_out), 0);
        chk("async_done", int'(done_out), 0);
        chk("async_result", int'(result_out), 0);
        chk("async_flag", int'(flag_out), 0);
        chk("async_ovf", int'(overflow_out), 0);
        idle_cycles(2);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b1;
        op_once(1'b0, 8'h02, 8'h03);

        // Start held high; operands change every cycle and only captured ones count
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end
        idle_cycles(W + 3);

        // Randomized traffic with random start density
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end
        idle_cycles(W + 4);

        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
